ms_sched: RTL and testbench

Round-robin scheduler that shares one maze-solver core among up to four requesters. It streams a granted requester's 225-bit serial maze (15x15, row-major) into the solver and returns the solver's path or invalid result, tagged with the requester ID. A watchdog resets a hung solver. It sits between the requester fabric and the solver core, and owns the solver's `in_valid`, `maze` and a local reset.

---
 rtl/ms_sched.sv | 172 +++++++++++++++++
 tb/tb_ms_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ms_sched.sv
// Round-robin scheduler sharing one maze-solver core among N_REQ requesters:
// streams the granted 225-bit maze in, forwards results, recovers a hung solver.
module ms_sched #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_bit,
  output logic [N_REQ-1:0] gnt,
  output logic             sol_in_valid,
  output logic             sol_maze,
  output logic             sol_rst_n,
  input  logic             sol_out_valid,
  input  logic             sol_not_valid,
  input  logic [3:0]       sol_x,
  input  logic [3:0]       sol_y,
  output logic             rsp_valid,
  output logic [1:0]       rsp_id,
  output logic             rsp_not_valid,
  output logic             rsp_timeout,
  output logic [3:0]       rsp_x,
  output logic [3:0]       rsp_y,
  output logic             rsp_done,
  output logic [7:0]       rsp_len
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, DRAIN, RECOVER} state_t;

  localparam logic [9:0] WD_LAST  = 10'(TIMEOUT - 1);
  localparam logic [7:0] LOAD_END = 8'd224;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [7:0]  r_cnt;
  logic [9:0]  r_wd;
  logic [7:0]  r_len;
  logic        r_rec;

  logic             w_any;
  logic [1:0]       w_win;
  logic [N_REQ-1:0] w_oh;
  logic [1:0]       w_ptr_nxt;
  logic             w_bit;
  int unsigned      w_ptr;
  int unsigned      w_dist;
  int unsigned      w_best;
  int unsigned      w_win_i;

  // Winner is the set request with the smallest rotational distance from r_ptr.
  always_comb begin
    w_any   = 1'b0;
    w_win   = '0;
    w_win_i = 0;
    w_oh    = '0;
    w_ptr   = {30'd0, r_ptr};
    w_best  = N_REQ;
    w_dist  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_dist = (i >= w_ptr) ? (i - w_ptr) : (i + N_REQ - w_ptr);
      if (req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_win_i = i;
        w_win   = 2'(i);
        w_any   = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_oh[i] = w_any && (w_win_i == i);
    end
    w_ptr_nxt = (w_win_i + 1 == N_REQ) ? 2'd0 : 2'(w_win_i + 1);
  end

  // The held one-hot grant selects the serial bit of the owning requester.
  assign w_bit = |(req_bit & gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_wd          <= '0;
      r_len         <= '0;
      r_rec         <= 1'b0;
      gnt           <= '0;
      sol_in_valid  <= 1'b0;
      sol_maze      <= 1'b0;
      sol_rst_n     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_not_valid <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_x         <= '0;
      rsp_y         <= '0;
      rsp_done      <= 1'b0;
      rsp_len       <= '0;
    end else begin
      sol_in_valid  <= 1'b0;
      sol_maze      <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_not_valid <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_done      <= 1'b0;
      rsp_len       <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            gnt     <= w_oh;
            rsp_id  <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          sol_in_valid <= 1'b1;
          sol_maze     <= w_bit;
          r_cnt        <= r_cnt + 8'd1;
          if (r_cnt == LOAD_END) begin
            gnt     <= '0;
            r_wd    <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_wd <= r_wd + 10'd1;
          if (sol_out_valid) begin
            rsp_valid     <= 1'b1;
            rsp_x         <= sol_x;
            rsp_y         <= sol_y;
            rsp_not_valid <= sol_not_valid;
            r_len         <= sol_not_valid ? 8'd0 : 8'd1;
            r_state       <= DRAIN;
          end else if (r_wd == WD_LAST) begin
            sol_rst_n     <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_timeout   <= 1'b1;
            rsp_not_valid <= 1'b1;
            rsp_done      <= 1'b1;
            r_rec         <= 1'b0;
            r_state       <= RECOVER;
          end
        end
        DRAIN: begin
          if (sol_out_valid) begin
            rsp_valid     <= 1'b1;
            rsp_x         <= sol_x;
            rsp_y         <= sol_y;
            rsp_not_valid <= sol_not_valid;
            if (!sol_not_valid && (r_len != 8'hFF)) r_len <= r_len + 8'd1;
          end else begin
            rsp_done <= 1'b1;
            rsp_len  <= r_len;
            r_state  <= IDLE;
          end
        end
        RECOVER: begin
          if (!r_rec) begin
            r_rec <= 1'b1;
          end else begin
            r_rec     <= 1'b0;
            sol_rst_n <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_sched.sv
// Directed bench for ms_sched: table of jobs acting as requester and solver,
// plus a hand-written mid-load asynchronous reset sequence.
module tb_ms_sched;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] req_bit = '0;
  logic [1:0] gnt;
  logic       sol_in_valid, sol_maze, sol_rst_n;
  logic       sol_out_valid = 1'b0;
  logic       sol_not_valid = 1'b0;
  logic [3:0] sol_x = '0;
  logic [3:0] sol_y = '0;
  logic       rsp_valid, rsp_not_valid, rsp_timeout, rsp_done;
  logic [1:0] rsp_id;
  logic [3:0] rsp_x, rsp_y;
  logic [7:0] rsp_len;

  ms_sched #(.N_REQ(2), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_bit(req_bit), .gnt(gnt),
    .sol_in_valid(sol_in_valid), .sol_maze(sol_maze), .sol_rst_n(sol_rst_n),
    .sol_out_valid(sol_out_valid), .sol_not_valid(sol_not_valid),
    .sol_x(sol_x), .sol_y(sol_y), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_not_valid(rsp_not_valid), .rsp_timeout(rsp_timeout), .rsp_x(rsp_x),
    .rsp_y(rsp_y), .rsp_done(rsp_done), .rsp_len(rsp_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mask;
    int         id;
    int         beats;
    bit         nv;
    bit         silent;
    int         len;
    int         pat;
  } vec_t;

  // gnt, in_valid, maze, sol_rst_n, rsp_valid, id, nv, timeout, x, y, done, len
  localparam logic [26:0] RST_VEC = {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                                     1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] outs();
    return {gnt, sol_in_valid, sol_maze, sol_rst_n, rsp_valid, rsp_id,
            rsp_not_valid, rsp_timeout, rsp_x, rsp_y, rsp_done, rsp_len};
  endfunction

  function automatic logic [224:0] mk_maze(input int pat);
    logic [224:0] m;
    for (int i = 0; i < 225; i++) m[i] = (((i * pat) + (i / 3)) % 5) < 2;
    return m;
  endfunction

  task automatic run_job(input vec_t v, input string tag);
    logic [224:0] m;
    logic [1:0]   oh;
    int           waitc, errs, beats_seen, done_rel, len_seen, rel;
    bit           done;
    m  = mk_maze(v.pat);
    oh = (v.id == 0) ? 2'b01 : 2'b10;
    req = v.mask;
    waitc = 0;
    while (gnt == 2'b00 && waitc < 20) begin
      tick();
      waitc++;
    end
    chk({tag, " gnt"}, 32'(gnt), 32'(oh));
    if (gnt == 2'b00) return;

    errs = 0;
    for (int k = 0; k < 225; k++) begin
      if (gnt !== oh) errs++;
      if (k >= 1 && (sol_in_valid !== 1'b1 || sol_maze !== m[k-1])) errs++;
      if (rsp_valid !== 1'b0) errs++;
      req[v.id] = 1'b0;
      req_bit = {2{~m[k]}};
      req_bit[v.id] = m[k];
      sol_out_valid = (k % 97 == 5);   // stray solver output during load must be dropped
      sol_x = 4'hA;
      sol_y = 4'h5;
      tick();
    end
    if (gnt !== 2'b00 || sol_in_valid !== 1'b1 || sol_maze !== m[224]) errs++;
    chk({tag, " load"}, 32'(errs), 0);

    errs = 0; beats_seen = 0; done = 1'b0; done_rel = -1; len_seen = -1;
    rel = 225;
    while (!done && rel < 225 + v.beats + 40) begin
      if (rel == 226 && sol_in_valid !== 1'b0) errs++;
      if (!v.silent && sol_rst_n !== 1'b1) errs++;
      if (rsp_valid === 1'b1) begin
        if (rsp_id !== 2'(v.id) || rsp_timeout !== v.silent ||
            rsp_not_valid !== (v.silent | v.nv)) errs++;
        if (!v.silent && (rsp_x !== 4'(beats_seen % 16) ||
                          rsp_y !== 4'(15 - beats_seen % 16))) errs++;
        beats_seen++;
      end
      if (rsp_done === 1'b1) begin
        done = 1'b1;
        done_rel = rel;
        len_seen = int'(rsp_len);
      end else begin
        sol_out_valid = !v.silent && rel >= 226 && rel < 226 + v.beats;
        sol_x = 4'((rel - 226) % 16);
        sol_y = 4'(15 - (rel - 226) % 16);
        sol_not_valid = v.nv;
        tick();
        rel++;
      end
    end
    sol_out_valid = 1'b0;
    sol_not_valid = 1'b0;
    chk({tag, " beats"}, 32'(beats_seen), v.silent ? 32'd1 : 32'(v.beats));
    chk({tag, " done_at"}, 32'(done_rel), v.silent ? 32'(225 + T) : 32'(227 + v.beats));
    chk({tag, " len"}, 32'(len_seen), 32'(v.len));
    chk({tag, " fields"}, 32'(errs), 0);
    if (v.silent) begin
      errs = 0;
      if (sol_rst_n !== 1'b0) errs++;
      tick();
      if (sol_rst_n !== 1'b0 || rsp_valid !== 1'b0) errs++;
      tick();
      if (sol_rst_n !== 1'b1) errs++;
      chk({tag, " recover"}, 32'(errs), 0);
    end
  endtask

  initial begin
    vec_t         tbl[6];
    logic [224:0] m;
    int           waitc;
    tbl[0] = '{mask: 2'b11, id: 0, beats: 3,   nv: 1'b0, silent: 1'b0, len: 3,   pat: 3};
    tbl[1] = '{mask: 2'b10, id: 1, beats: 1,   nv: 1'b1, silent: 1'b0, len: 0,   pat: 7};
    tbl[2] = '{mask: 2'b11, id: 0, beats: 25,  nv: 1'b0, silent: 1'b0, len: 25,  pat: 11};
    tbl[3] = '{mask: 2'b11, id: 1, beats: 0,   nv: 1'b0, silent: 1'b1, len: 0,   pat: 5};
    tbl[4] = '{mask: 2'b01, id: 0, beats: 5,   nv: 1'b0, silent: 1'b0, len: 5,   pat: 13};
    tbl[5] = '{mask: 2'b10, id: 1, beats: 300, nv: 1'b0, silent: 1'b0, len: 255, pat: 2};

    tick();
    tick();
    chk("reset_state", 32'(outs()), 32'(RST_VEC));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_job(tbl[i], $sformatf("job%0d", i));

    // Asynchronous reset in the middle of a load, request held throughout.
    m = mk_maze(9);
    req = 2'b01;
    waitc = 0;
    while (gnt == 2'b00 && waitc < 20) begin
      tick();
      waitc++;
    end
    chk("rst_job gnt", 32'(gnt), 32'd1);
    for (int k = 0; k < 100; k++) begin
      req_bit = {1'b0, m[k]};
      tick();
    end
    chk("rst_job loading", 32'(sol_in_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(outs()), 32'(RST_VEC));
    tick();
    tick();
    chk("reset_hold", 32'(outs()), 32'(RST_VEC));
    rst_n = 1'b1;
    run_job('{mask: 2'b01, id: 0, beats: 4, nv: 1'b0, silent: 1'b0, len: 4, pat: 17}, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
